// File: rtl/hit_pkg.sv
// Shared types and widths for the hazard hit manager: FSM state encoding,
// lives/penalty widths and the saturating penalty adder.
package hit_pkg;

    localparam int LIVES_W = 4;
    localparam int DEAD_W  = 9;
    localparam int FRAME_W = 8;
    localparam int BLINK_W = 4;
    localparam logic [DEAD_W-1:0] DEAD_MAX = 9'd511;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DYING     = 2'd1,
        INVULN    = 2'd2,
        GAME_OVER = 2'd3
    } hit_state_t;

    function automatic logic [DEAD_W-1:0] sat_add(input logic [DEAD_W-1:0] a,
                                                  input logic [DEAD_W-1:0] b);
        logic [DEAD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, DEAD_MAX}) ? DEAD_MAX : sum[DEAD_W-1:0];
    endfunction

endpackage

// File: rtl/hazard_hit_manager_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// The pulse is high for one Clk cycle, three cycles after the input rises.
module sync_rise_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic din,
    output logic rise
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic last_q, last_d;
    logic rise_q, rise_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        last_d = sync_q;
        rise_d = sync_q & ~last_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            last_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            last_q <= last_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/hazard_hit_manager.sv
// Lives/penalty bookkeeping for hazard hits: respawn sequencing, invulnerability
// window with sprite blinking, and game-over hold until restart.
//
//   state     | meaning
//   ALIVE     | playable; a hit costs a life and adds the penalty
//   DYING     | sprite hidden, waiting RESPAWN_FRAMES before respawn
//   INVULN    | hits ignored, sprite blinks for INVULN_FRAMES
//   GAME_OVER | no lives left, waiting for restart
module hazard_hit_manager
    import hit_pkg::*;
#(
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned DEAD_OFFSET    = 10,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned INVULN_FRAMES  = 90,
    parameter int unsigned BLINK_PERIOD   = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               hit_in,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic [DEAD_W-1:0]  dead_times,
    output logic               game_over,
    output logic               invuln,
    output logic               mario_visible,
    output logic               respawn_req
);
    localparam logic [LIVES_W-1:0] LIVES_RST   = LIVES_W'(LIVES_INIT);
    localparam logic [DEAD_W-1:0]  DEAD_INC    = DEAD_W'(DEAD_OFFSET);
    localparam logic [FRAME_W-1:0] RESP_LAST   = FRAME_W'(RESPAWN_FRAMES - 1);
    localparam logic [FRAME_W-1:0] INVULN_LAST = FRAME_W'(INVULN_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_PERIOD - 1);

    logic frame_tick, hit_rise, restart_rise;

    sync_rise_detect u_frame_sync   (.Clk(Clk), .Reset(Reset), .din(frame_clk), .rise(frame_tick));
    sync_rise_detect u_hit_sync     (.Clk(Clk), .Reset(Reset), .din(hit_in),    .rise(hit_rise));
    sync_rise_detect u_restart_sync (.Clk(Clk), .Reset(Reset), .din(restart),   .rise(restart_rise));

    hit_state_t         state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [DEAD_W-1:0]  dead_q, dead_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               visible_q, visible_d;
    logic               respawn_q, respawn_d;

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        dead_d      = dead_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        visible_d   = visible_q;
        respawn_d   = 1'b0;

        if (restart_rise) begin
            state_d     = ALIVE;
            lives_d     = LIVES_RST;
            dead_d      = '0;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            visible_d   = 1'b1;
            respawn_d   = 1'b1;
        end else begin
            unique case (state_q)
                ALIVE: begin
                    if (hit_rise) begin
                        dead_d    = sat_add(dead_q, DEAD_INC);
                        visible_d = 1'b0;
                        // lives of 0 cannot normally occur in ALIVE; treat it as final too
                        if (lives_q <= LIVES_W'(1)) begin
                            lives_d = '0;
                            state_d = GAME_OVER;
                        end else begin
                            lives_d     = lives_q - LIVES_W'(1);
                            frame_cnt_d = '0;
                            state_d     = DYING;
                        end
                    end
                end
                DYING: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == RESP_LAST) begin
                            respawn_d   = 1'b1;
                            frame_cnt_d = '0;
                            blink_cnt_d = '0;
                            visible_d   = 1'b1;
                            state_d     = INVULN;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                        end
                    end
                end
                INVULN: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == INVULN_LAST) begin
                            frame_cnt_d = '0;
                            blink_cnt_d = '0;
                            visible_d   = 1'b1;
                            state_d     = ALIVE;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                            if (blink_cnt_q == BLINK_LAST) begin
                                visible_d   = ~visible_q;
                                blink_cnt_d = '0;
                            end else begin
                                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                            end
                        end
                    end
                end
                GAME_OVER: begin
                    visible_d = 1'b0;
                end
                default: state_d = ALIVE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ALIVE;
            lives_q     <= LIVES_RST;
            dead_q      <= '0;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
            visible_q   <= 1'b1;
            respawn_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            dead_q      <= dead_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            visible_q   <= visible_d;
            respawn_q   <= respawn_d;
        end
    end

    assign lives         = lives_q;
    assign dead_times    = dead_q;
    assign mario_visible = visible_q;
    assign respawn_req   = respawn_q;
    assign game_over     = (state_q == GAME_OVER);
    assign invuln        = (state_q == DYING) || (state_q == INVULN);

endmodule
